// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// The result and leading-zero flags are updated only when a conversion completes.
module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  START,
  input  logic [WIDTH-1:0]      BIN,
  output logic                  READY,
  output logic                  DONE,
  output logic [4*DIGITS-1:0]   BCD,
  output logic [DIGITS-1:0]     BLANK
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  if (pow10(DIGITS) < (64'd1 << WIDTH)) begin : g_range_err
    $error("bin2bcd_seq: DIGITS too small to hold 2**WIDTH-1");
  end

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_FINISH} state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    sh_bin_q, sh_bin_d;
  logic [4*DIGITS-1:0] sh_bcd_q, sh_bcd_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic [DIGITS-1:0]   blank_q, blank_d;
  logic                done_q, done_d;

  logic [4*DIGITS-1:0] adj;
  logic [DIGITS:1]     zero_up;
  logic [DIGITS-1:0]   blank_calc;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    assign adj[4*gi +: 4] = (sh_bcd_q[4*gi +: 4] >= 4'd5) ? sh_bcd_q[4*gi +: 4] + 4'd3
                                                          : sh_bcd_q[4*gi +: 4];
  end

  // zero_up[k] = digits k..DIGITS-1 of the scratch result are all zero
  assign zero_up[DIGITS] = 1'b1;
  for (genvar gi = 1; gi < DIGITS; gi++) begin : g_zero
    assign zero_up[gi] = zero_up[gi+1] & (sh_bcd_q[4*gi +: 4] == 4'd0);
  end
  assign blank_calc = {zero_up[DIGITS-1:1], 1'b0};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      sh_bin_q <= '0;
      sh_bcd_q <= '0;
      cnt_q    <= '0;
      bcd_q    <= '0;
      blank_q  <= BLANK_RST;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_bin_q <= sh_bin_d;
      sh_bcd_q <= sh_bcd_d;
      cnt_q    <= cnt_d;
      bcd_q    <= bcd_d;
      blank_q  <= blank_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sh_bin_d = sh_bin_q;
    sh_bcd_d = sh_bcd_q;
    cnt_d    = cnt_q;
    bcd_d    = bcd_q;
    blank_d  = blank_q;
    done_d   = 1'b0;
    READY    = 1'b0;
    case (state_q)
      S_IDLE: begin
        READY = 1'b1;
        if (START) begin
          sh_bin_d = BIN;
          sh_bcd_d = '0;
          cnt_d    = CW'(WIDTH);
          state_d  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        {sh_bcd_d, sh_bin_d} = {adj[4*DIGITS-2:0], sh_bin_q, 1'b0};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FINISH;
      end
      S_FINISH: begin
        bcd_d   = sh_bcd_q;
        blank_d = blank_calc;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign DONE  = done_q;
  assign BCD   = bcd_q;
  assign BLANK = blank_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: an 8-bit/3-digit instance and a 10-bit/4-digit instance,
// both checked against a divide-by-ten decimal model.
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, start2;
  logic [7:0]  bin;
  logic [9:0]  bin2;
  logic        ready, done, ready2, done2;
  logic [11:0] bcd;
  logic [2:0]  blank;
  logic [15:0] bcd2;
  logic [3:0]  blank2;

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .CLK(clk), .RST_N(rst_n), .START(start), .BIN(bin),
    .READY(ready), .DONE(done), .BCD(bcd), .BLANK(blank));

  bin2bcd_seq #(.WIDTH(10), .DIGITS(4)) dut2 (
    .CLK(clk), .RST_N(rst_n), .START(start2), .BIN(bin2),
    .READY(ready2), .DONE(done2), .BCD(bcd2), .BLANK(blank2));

  int n_checks = 0;
  int n_fail   = 0;
  logic [19:0] exp_q[$];
  logic [19:0] exp2_q[$];
  int cyc = 0, last_done_cyc = 0, last_gap = 0, done_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {blank[3:0], bcd[15:0]} for nd decimal digits
  function automatic logic [19:0] model(input int v, input int nd);
    logic [15:0] b;
    logic [3:0]  bl;
    int t, p;
    b = '0; bl = '0; t = v; p = 1;
    for (int k = 0; k < nd; k++) begin
      b[4*k +: 4] = 4'(t % 10);
      t = t / 10;
      if (k > 0) bl[k] = (v < p);
      p = p * 10;
    end
    return {bl, b};
  endfunction

  function automatic logic digits_ok(input logic [15:0] b, input int nd);
    for (int k = 0; k < nd; k++) if (b[4*k +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    logic [19:0] e;
    if (rst_n) begin
      cyc++;
      check_eq("digit_range", digits_ok({4'd0, bcd}, 3), 1);
      check_eq("digit_range2", digits_ok(bcd2, 4), 1);
      if (done) begin
        done_cnt++;
        last_gap = cyc - last_done_cyc - 1;
        last_done_cyc = cyc;
        if (exp_q.size() == 0) check_eq("unexpected_done", 1, 0);
        else begin
          e = exp_q.pop_front();
          $display("conv8  bcd=%h blank=%b exp=%h/%b", bcd, blank, e[11:0], e[18:16]);
          check_eq("bcd", bcd, e[11:0]);
          check_eq("blank", blank, e[18:16]);
        end
      end
      if (done2) begin
        if (exp2_q.size() == 0) check_eq("unexpected_done2", 1, 0);
        else begin
          e = exp2_q.pop_front();
          $display("conv10 bcd=%h blank=%b exp=%h/%b", bcd2, blank2, e[15:0], e[19:16]);
          check_eq("bcd2", bcd2, e[15:0]);
          check_eq("blank2", blank2, e[19:16]);
        end
      end
    end
  end

  task automatic drive(input logic [7:0] v);
    int guard = 0;
    @(negedge clk);
    while (!ready && guard < 100) begin @(negedge clk); guard++; end
    check_eq("drive_ready", guard < 100, 1);
    start = 1'b1; bin = v;
    exp_q.push_back(model(int'(v), 3));
    @(negedge clk);
    start = 1'b0; bin = 8'($urandom);
  endtask

  task automatic drive2(input logic [9:0] v);
    int guard = 0;
    @(negedge clk);
    while (!ready2 && guard < 100) begin @(negedge clk); guard++; end
    check_eq("drive2_ready", guard < 100, 1);
    start2 = 1'b1; bin2 = v;
    exp2_q.push_back(model(int'(v), 4));
    @(negedge clk);
    start2 = 1'b0; bin2 = 10'($urandom);
  endtask

  task automatic drain();
    int guard = 0;
    while ((exp_q.size() != 0 || exp2_q.size() != 0 || !ready || !ready2) && guard < 200) begin
      @(negedge clk); guard++;
    end
    check_eq("drain_timeout", guard < 200, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nrdy, dc;
    logic [7:0] vals [4] = '{8'd255, 8'd7, 8'd99, 8'd100};
    logic [9:0] vals2 [8] = '{10'd0, 10'd9, 10'd10, 10'd99, 10'd100, 10'd999, 10'd1000, 10'd1023};
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0; bin = '0; bin2 = '0;
    #12;
    check_eq("rst_ready", ready, 1);
    check_eq("rst_done", done, 0);
    check_eq("rst_bcd", bcd, 12'h000);
    check_eq("rst_blank", blank, 3'b110);
    check_eq("rst_blank2", blank2, 4'b1110);
    @(negedge clk); rst_n = 1'b1;

    // Zero value with latency measurement
    @(negedge clk);
    start = 1'b1; bin = 8'd0; exp_q.push_back(model(0, 3));
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    do begin @(posedge clk); n++; #1; end while (!done && n < 50);
    check_eq("latency", n, 9);
    check_eq("ready_in_done", ready, 1);
    drain();

    foreach (vals[i]) drive(vals[i]);
    drain();

    // START held and BIN changing during conversion: only the first value counts
    @(negedge clk);
    dc = done_cnt;
    start = 1'b1; bin = 8'd123; exp_q.push_back(model(123, 3));
    nrdy = 0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (!ready) nrdy++;
      bin = 8'($urandom);
      if (i == 9) start = 1'b0;
    end
    check_eq("busy_cycles", nrdy, 9);
    drain();
    check_eq("one_done", done_cnt - dc, 1);

    // Reset in the middle of a conversion
    @(negedge clk);
    start = 1'b1; bin = 8'd200;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_eq("abort_ready", ready, 1);
    check_eq("abort_bcd", bcd, 12'h000);
    check_eq("abort_blank", blank, 3'b110);
    check_eq("abort_done", done, 0);
    dc = done_cnt;
    @(negedge clk); rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("no_done_after_abort", done_cnt - dc, 0);

    // Back-to-back: second START in the DONE cycle
    @(negedge clk);
    start = 1'b1; bin = 8'd42; exp_q.push_back(model(42, 3));
    @(negedge clk); start = 1'b0;
    n = 0;
    while (!done && n < 50) begin @(negedge clk); n++; end
    check_eq("b2b_ready_in_done", ready, 1);
    start = 1'b1; bin = 8'd43; exp_q.push_back(model(43, 3));
    @(negedge clk); start = 1'b0;
    drain();
    check_eq("b2b_gap", last_gap, 9);

    // Exhaustive sweep, then the result must hold while idle
    for (int v = 0; v < 256; v++) drive(8'(v));
    drain();
    repeat (5) @(negedge clk);
    check_eq("hold_bcd", bcd, 12'h255);
    check_eq("hold_blank", blank, 3'b000);

    foreach (vals2[i]) drive2(vals2[i]);
    for (int i = 0; i < 20; i++) drive2(10'($urandom));
    drain();

    check_eq("queue_empty", exp_q.size() + exp2_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
